// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Flow per operation: accept in IDLE, drive the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTRL_WIDTH-1:0] req0_ALU_Control,
    input  logic [DATA_WIDTH-1:0] req0_operand_A,
    input  logic [DATA_WIDTH-1:0] req0_operand_B,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTRL_WIDTH-1:0] req1_ALU_Control,
    input  logic [DATA_WIDTH-1:0] req1_operand_A,
    input  logic [DATA_WIDTH-1:0] req1_operand_B,
    output logic                  resp0_valid,
    output logic                  resp1_valid,
    input  logic                  resp0_ready,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp_ALU_result,
    output logic                  resp_zero,
    output logic                  resp_branch,
    output logic [CTRL_WIDTH-1:0] ALU_Control,
    output logic [DATA_WIDTH-1:0] operand_A,
    output logic [DATA_WIDTH-1:0] operand_B,
    input  logic [DATA_WIDTH-1:0] ALU_result,
    input  logic                  zero,
    input  logic                  branch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic last_grant;
    logic owner;
    logic grant0, grant1;
    logic accept0, accept1;
    logic resp_ack;

    logic [CTRL_WIDTH-1:0] op_ctrl_p0;
    logic [DATA_WIDTH-1:0] op_a_p0;
    logic [DATA_WIDTH-1:0] op_b_p0;

    logic [DATA_WIDTH-1:0] res_p1;
    logic                  zero_p1;
    logic                  branch_p1;

    always_comb begin
        state_next = state;
        // On a tie the requester that was not served last wins.
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == IDLE) && grant0 && reset;
        req1_ready = (state == IDLE) && grant1 && reset;
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
        resp_ack   = (state == RESP) && (owner ? resp1_ready : resp0_ready);

        case (state)
            IDLE: if (accept0 || accept1) state_next = EXEC;
            EXEC: state_next = RESP;
            RESP: if (resp_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_ctrl_p0 <= '0;
            op_a_p0    <= '0;
            op_b_p0    <= '0;
            res_p1     <= '0;
            zero_p1    <= 1'b0;
            branch_p1  <= 1'b0;
        end else begin
            state <= state_next;
            // Stage p0: operand capture at acceptance
            if (accept0 || accept1) begin
                owner      <= accept1;
                last_grant <= accept1;
                op_ctrl_p0 <= accept1 ? req1_ALU_Control : req0_ALU_Control;
                op_a_p0    <= accept1 ? req1_operand_A   : req0_operand_A;
                op_b_p0    <= accept1 ? req1_operand_B   : req0_operand_B;
            end
            // Stage p1: ALU result capture at the end of EXEC
            if (state == EXEC) begin
                res_p1    <= ALU_result;
                zero_p1   <= zero;
                branch_p1 <= branch;
            end
        end
    end

    assign ALU_Control     = op_ctrl_p0;
    assign operand_A       = op_a_p0;
    assign operand_B       = op_b_p0;
    assign resp_ALU_result = res_p1;
    assign resp_zero       = zero_p1;
    assign resp_branch     = branch_p1;
    assign resp0_valid     = (state == RESP) && !owner;
    assign resp1_valid     = (state == RESP) && owner;

endmodule
